// File: rtl/model_pkg.sv
// Shared types and constants for the quantized CNN datapath input stage.
// The constants give the shape of one input-activation frame.
package model_pkg;

  localparam int unsigned CONV2_XD = 64;
  localparam int unsigned CONV2_XB = 11;

  typedef logic [CONV2_XB-1:0] x_word_t;
  typedef x_word_t [CONV2_XD-1:0] x_frame_t;

  typedef enum logic {
    BUF0 = 1'b0,
    BUF1 = 1'b1
  } buf_sel_e;

  function automatic buf_sel_e other_buf(input buf_sel_e sel);
    return (sel == BUF0) ? BUF1 : BUF0;
  endfunction

endpackage

// File: rtl/x_frame_buf.sv
// One XD x XB register bank.
// Writes a single word per cycle at waddr_i and exposes the whole frame in parallel.
module x_frame_buf
  import model_pkg::*;
#(
  parameter int unsigned XD = CONV2_XD,
  parameter int unsigned XB = CONV2_XB,
  parameter int unsigned CW = (XD > 1) ? $clog2(XD) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   we_i,
  input  logic [CW-1:0]          waddr_i,
  input  logic [XB-1:0]          wdata_i,
  output logic [XD-1:0][XB-1:0]  data_o
);

  logic [XD-1:0][XB-1:0] mem_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign data_o = mem_q;

endmodule

// File: rtl/x_frame_loader.sv
// Ping-pong frame loader: assembles serial activation words into XD-word frames
// and presents each complete frame in parallel, held stable until consumed.
module x_frame_loader
  import model_pkg::*;
#(
  parameter int unsigned XD = CONV2_XD,
  parameter int unsigned XB = CONV2_XB
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [XB-1:0]          s_data,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [XD-1:0][XB-1:0]  m_data,
  output logic                   err,
  output logic [15:0]            frame_cnt
);

  localparam int unsigned CW = (XD > 1) ? $clog2(XD) : 1;
  localparam logic [CW-1:0] WLAST = CW'(XD - 1);

  buf_sel_e          wsel_q, wsel_d;
  buf_sel_e          rsel_q, rsel_d;
  logic [1:0]        full_q, full_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;
  logic              err_q, err_d;
  logic [15:0]       fcnt_q, fcnt_d;

  logic              in_beat, out_beat, at_last, commit, short_frame;
  logic              we0, we1;
  logic [XD-1:0][XB-1:0] buf0_data, buf1_data;

  assign s_ready     = ~full_q[wsel_q];
  assign m_valid     = full_q[rsel_q];
  assign in_beat     = s_valid & s_ready;
  assign out_beat    = m_valid & m_ready;
  assign at_last     = (wcnt_q == WLAST);
  assign commit      = in_beat & at_last;
  assign short_frame = in_beat & s_last & ~at_last;

  assign we0 = in_beat & (wsel_q == BUF0);
  assign we1 = in_beat & (wsel_q == BUF1);

  x_frame_buf #(.XD(XD), .XB(XB), .CW(CW)) u_buf0 (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (we0),
    .waddr_i (wcnt_q),
    .wdata_i (s_data),
    .data_o  (buf0_data)
  );

  x_frame_buf #(.XD(XD), .XB(XB), .CW(CW)) u_buf1 (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (we1),
    .waddr_i (wcnt_q),
    .wdata_i (s_data),
    .data_o  (buf1_data)
  );

  assign m_data    = (rsel_q == BUF1) ? buf1_data : buf0_data;
  assign err       = err_q;
  assign frame_cnt = fcnt_q;

  // Commit and drain always target different buffers (s_ready blocks a full
  // write buffer), so both updates to full_d can apply in the same cycle.
  always_comb begin
    wsel_d = wsel_q;
    rsel_d = rsel_q;
    full_d = full_q;
    wcnt_d = wcnt_q;
    err_d  = 1'b0;
    fcnt_d = fcnt_q;

    if (out_beat) begin
      full_d[rsel_q] = 1'b0;
      rsel_d         = other_buf(rsel_q);
    end

    if (commit) begin
      full_d[wsel_q] = 1'b1;
      wsel_d         = other_buf(wsel_q);
      wcnt_d         = '0;
      fcnt_d         = fcnt_q + 16'd1;
      err_d          = ~s_last;
    end else if (short_frame) begin
      wcnt_d = '0;
      err_d  = 1'b1;
    end else if (in_beat) begin
      wcnt_d = wcnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wsel_q <= BUF0;
      rsel_q <= BUF0;
      full_q <= '0;
      wcnt_q <= '0;
      err_q  <= 1'b0;
      fcnt_q <= '0;
    end else begin
      wsel_q <= wsel_d;
      rsel_q <= rsel_d;
      full_q <= full_d;
      wcnt_q <= wcnt_d;
      err_q  <= err_d;
      fcnt_q <= fcnt_d;
    end
  end

endmodule

// File: tb/tb_x_frame_loader.sv
// Directed bench for x_frame_loader: basic frame, backpressure, short and
// unterminated frames, back-to-back streaming and mid-frame reset.
module tb_x_frame_loader;

  localparam int unsigned XD = 64;
  localparam int unsigned XB = 11;

  logic                  clk;
  logic                  rst;
  logic                  s_valid;
  logic                  s_ready;
  logic [XB-1:0]         s_data;
  logic                  s_last;
  logic                  m_valid;
  logic                  m_ready;
  logic [XD-1:0][XB-1:0] m_data;
  logic                  err;
  logic [15:0]           frame_cnt;

  int unsigned n_checks;
  int unsigned n_errors;
  int unsigned err_pulses;
  int unsigned stalls;

  x_frame_loader #(.XD(XD), .XB(XB)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .err       (err),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err === 1'b1) err_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one word, waits (bounded) for s_ready, completes the beat, and
  // returns 1 time unit after the accepting edge with s_valid still high.
  task automatic send(input logic [XB-1:0] d, input logic l);
    int unsigned n;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    n = 0;
    while (s_ready !== 1'b1) begin
      stalls++;
      tick();
      n++;
      if (n > 200) begin
        check("s_ready_timeout", 32'(s_ready), 32'd1);
        break;
      end
    end
    tick();
  endtask

  task automatic idle();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic pulse_mready();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  initial begin
    int unsigned e0;
    n_checks   = 0;
    n_errors   = 0;
    err_pulses = 0;
    stalls     = 0;
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    #1;
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_fcnt", 32'(frame_cnt), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_mdata0", 32'(m_data[0]), 32'd0);
    check("rst_mdata63", 32'(m_data[63]), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Basic frame: words i-32, consumer ready
    e0 = err_pulses;
    m_ready = 1'b1;
    for (int i = 0; i < 64; i++) send(11'(i - 32), (i == 63));
    idle();
    check("basic_m_valid", 32'(m_valid), 32'd1);
    check("basic_mdata0", 32'(m_data[0]), 32'h7E0);
    check("basic_mdata40", 32'(m_data[40]), 32'd8);
    check("basic_mdata63", 32'(m_data[63]), 32'd31);
    check("basic_fcnt", 32'(frame_cnt), 32'd1);
    tick();
    check("basic_drained", 32'(m_valid), 32'd0);
    check("basic_no_err", err_pulses - e0, 32'd0);
    m_ready = 1'b0;

    // Backpressure: frames A (i) and B (i+100) fill both buffers
    for (int i = 0; i < 64; i++) send(11'(i), (i == 63));
    for (int i = 0; i < 64; i++) send(11'(i + 100), (i == 63));
    check("bp_s_ready_low", 32'(s_ready), 32'd0);
    check("bp_fcnt", 32'(frame_cnt), 32'd3);
    s_valid = 1'b1;
    s_data  = 11'd500;
    s_last  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("bp_stall_ready", 32'(s_ready), 32'd0);
      check("bp_hold_mdata5", 32'(m_data[5]), 32'd5);
    end
    check("bp_hold_mdata63", 32'(m_data[63]), 32'd63);
    pulse_mready();
    check("bp_switch_mdata5", 32'(m_data[5]), 32'd105);
    check("bp_switch_valid", 32'(m_valid), 32'd1);
    check("bp_s_ready_back", 32'(s_ready), 32'd1);
    for (int i = 0; i < 64; i++) send(11'(500 + i), (i == 63));
    idle();
    check("bp_c_fcnt", 32'(frame_cnt), 32'd4);
    check("bp_b_still", 32'(m_data[0]), 32'd100);
    pulse_mready();
    check("bp_c_mdata0", 32'(m_data[0]), 32'd500);
    check("bp_c_mdata63", 32'(m_data[63]), 32'd563);
    pulse_mready();
    check("bp_empty", 32'(m_valid), 32'd0);

    // Short frame: s_last on word 9
    e0 = err_pulses;
    for (int i = 0; i < 10; i++) send(11'h2AA, (i == 9));
    idle();
    check("short_err", 32'(err), 32'd1);
    check("short_fcnt", 32'(frame_cnt), 32'd4);
    check("short_m_valid", 32'(m_valid), 32'd0);
    tick();
    check("short_err_clear", 32'(err), 32'd0);
    check("short_one_pulse", err_pulses - e0, 32'd1);
    for (int i = 0; i < 64; i++) send(11'h155, (i == 63));
    idle();
    check("after_short_valid", 32'(m_valid), 32'd1);
    check("after_short_fcnt", 32'(frame_cnt), 32'd5);
    check("after_short_err", 32'(err), 32'd0);
    for (int i = 0; i < 64; i += 9) check("after_short_word", 32'(m_data[i]), 32'h155);
    check("after_short_w63", 32'(m_data[63]), 32'h155);
    pulse_mready();

    // Missing s_last: committed anyway, err on word 63
    e0 = err_pulses;
    for (int i = 0; i < 64; i++) begin
      send(11'(3 * i), 1'b0);
      if (i == 62) check("nolast_no_early_err", 32'(err), 32'd0);
    end
    idle();
    check("nolast_err", 32'(err), 32'd1);
    check("nolast_valid", 32'(m_valid), 32'd1);
    check("nolast_fcnt", 32'(frame_cnt), 32'd6);
    check("nolast_mdata63", 32'(m_data[63]), 32'd189);
    tick();
    check("nolast_one_pulse", err_pulses - e0, 32'd1);
    pulse_mready();

    // Streaming: 10 back-to-back frames, consumer always ready
    e0 = err_pulses;
    stalls = 0;
    m_ready = 1'b1;
    for (int f = 0; f < 10; f++) begin
      for (int i = 0; i < 64; i++) send(11'(f * 7 + i * 13), (i == 63));
      check("stream_valid", 32'(m_valid), 32'd1);
      check("stream_mdata0", 32'(m_data[0]), 32'(11'(f * 7)));
      check("stream_mdata63", 32'(m_data[63]), 32'(11'(f * 7 + 63 * 13)));
    end
    idle();
    check("stream_no_stall", stalls, 32'd0);
    check("stream_fcnt", 32'(frame_cnt), 32'd16);
    tick();
    check("stream_no_err", err_pulses - e0, 32'd0);
    check("stream_drained", 32'(m_valid), 32'd0);
    m_ready = 1'b0;

    // Reset mid-frame with frame 1 pending
    for (int i = 0; i < 64; i++) send(11'(i + 1), (i == 63));
    for (int i = 0; i < 31; i++) send(11'h7FF, 1'b0);
    idle();
    check("pre_rst_valid", 32'(m_valid), 32'd1);
    check("pre_rst_s_ready", 32'(s_ready), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(m_valid), 32'd0);
    check("midrst_s_ready", 32'(s_ready), 32'd1);
    check("midrst_fcnt", 32'(frame_cnt), 32'd0);
    check("midrst_mdata0", 32'(m_data[0]), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 64; i++) send(11'(63 - i), (i == 63));
    idle();
    check("post_rst_valid", 32'(m_valid), 32'd1);
    check("post_rst_mdata0", 32'(m_data[0]), 32'd63);
    check("post_rst_mdata31", 32'(m_data[31]), 32'd32);
    check("post_rst_mdata63", 32'(m_data[63]), 32'd0);
    check("post_rst_fcnt", 32'(frame_cnt), 32'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
